riscv_fetch_fifo_param: RTL



---
 rtl/riscv_fetch_fifo_param.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/riscv_fetch_fifo_param.sv
// Instruction prefetch buffer for the IF stage: stores fetched words and realigns
// mixed 16/32-bit instructions, including 32-bit instructions that span two words.
module riscv_fetch_fifo_param #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [31:0]       in_rdata_i,
  input  logic              in_err_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_rdata_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_is_compressed_o,
  output logic              out_err_o,
  output logic              out_valid_stored_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  err_q, err_d;
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [ADDR_W-3:0] addr_q [DEPTH];
  logic [ADDR_W-3:0] addr_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              hp_q, hp_d;
  logic              ovf_q, ovf_d;

  logic              empty, hp_eff, is_comp;
  logic              head_valid, head_valid_st;
  logic [31:0]       w0;
  logic [15:0]       w1_lo;
  logic              e0, e1, w1_valid, w1_valid_st;
  logic              pop, shift, shift_st, full_no_shift, wr;
  logic [CNT_W-1:0]  push_idx;

  assign empty = (count_q == '0);

  // Head word comes from entry 0, or straight from the fetch port when empty.
  always_comb begin
    w0            = data_q[0];
    e0            = err_q[0];
    hp_eff        = hp_q;
    head_valid    = valid_q[0];
    head_valid_st = valid_q[0];
    w1_lo         = in_rdata_i[15:0];
    e1            = in_err_i;
    w1_valid      = 1'b0;
    w1_valid_st   = 1'b0;
    if (empty) begin
      w0            = in_rdata_i;
      e0            = in_err_i;
      hp_eff        = in_addr_i[1];
      head_valid    = in_valid_i;
      head_valid_st = 1'b0;
    end else if (valid_q[1]) begin
      w1_lo       = data_q[1][15:0];
      e1          = err_q[1];
      w1_valid    = 1'b1;
      w1_valid_st = 1'b1;
    end else begin
      w1_valid = in_valid_i;
    end
  end

  assign is_comp = hp_eff ? (w0[17:16] != 2'b11) : (w0[1:0] != 2'b11);

  assign out_rdata_o         = hp_eff ? {w1_lo, w0[31:16]} : w0;
  assign out_err_o           = e0 | (hp_eff & ~is_comp & e1);
  assign out_is_compressed_o = is_comp;
  assign out_valid_o         = head_valid & (~hp_eff | is_comp | w1_valid);
  assign out_valid_stored_o  = head_valid_st & (~hp_eff | is_comp | w1_valid_st);
  assign out_addr_o          = empty ? in_addr_i : {addr_q[0], hp_q, 1'b0};

  assign in_ready_o = (count_q <= CNT_W'(DEPTH - 1 - SKID));
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

  // Only an aligned compressed pop keeps the head word; everything else retires it.
  assign pop           = out_valid_o & out_ready_i;
  assign shift         = pop & (hp_eff | ~is_comp);
  assign shift_st      = shift & ~empty;
  assign push_idx      = count_q - CNT_W'(shift_st);
  assign full_no_shift = (count_q == CNT_W'(DEPTH)) & ~shift_st;
  assign wr            = in_valid_i & ~(empty & shift) & ~full_no_shift;

  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    data_d  = data_q;
    addr_d  = addr_q;
    hp_d    = hp_q;
    ovf_d   = ovf_q | (in_valid_i & full_no_shift);
    count_d = count_q - CNT_W'(shift_st) + CNT_W'(wr);
    if (shift_st) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        valid_d[i] = valid_q[i+1];
        err_d[i]   = err_q[i+1];
        data_d[i]  = data_q[i+1];
        addr_d[i]  = addr_q[i+1];
      end
      valid_d[DEPTH-1] = 1'b0;
    end
    if (wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_idx == CNT_W'(i)) begin
          valid_d[i] = 1'b1;
          err_d[i]   = in_err_i;
          data_d[i]  = in_rdata_i;
          addr_d[i]  = in_addr_i[ADDR_W-1:2];
        end
      end
    end
    if (pop) begin
      hp_d = hp_eff ^ is_comp;
    end else if (empty && wr) begin
      hp_d = in_addr_i[1];
    end
    if (clear_i) begin
      valid_d = '0;
      count_d = '0;
      hp_d    = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      count_q <= '0;
      hp_q    <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      count_q <= count_d;
      hp_q    <= hp_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        addr_q[i] <= addr_d[i];
      end
    end
  end

endmodule
